cdb_arbiter: RTL and testbench

//  Round-robin arbiter and driver for the common data bus (CDB) in the Tomasulo core.

---
 rtl/cdb_arbiter_if.sv | 29 ++
 rtl/cdb_arbiter.sv | 92 +++++++++
 tb/tb_cdb_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if
//   Common data bus bundle between the functional-unit requesters and the
//   CDB arbiter.
//   Requester side (master): req, req_label, req_data.
//   Arbiter side (slave):    grant, BCEN, BClabel, BCdata.
//   Unit i occupies req_label[i*LW +: LW] and req_data[i*DW +: DW].
interface cdb_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 32,
    parameter int unsigned LW   = 5
);
    logic [NREQ-1:0]    req;
    logic [NREQ*LW-1:0] req_label;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    grant;
    logic               BCEN;
    logic [LW-1:0]      BClabel;
    logic [DW-1:0]      BCdata;

    modport master (
        output req, req_label, req_data,
        input  grant, BCEN, BClabel, BCdata
    );

    modport slave (
        input  req, req_label, req_data,
        output grant, BCEN, BClabel, BCdata
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Round-robin arbiter and driver for the Tomasulo common data bus. Each
//   cycle one requesting unit is granted and its label/data are broadcast
//   for one cycle to all reservation stations and the register file.
// Ports:
//   clk       clock, rising edge
//   nRST      asynchronous active-low reset
//   flush     synchronous clear of pending grant/broadcast, pointer to 0
//   bus       CDB bundle (slave side): req/req_label/req_data in,
//             grant/BCEN/BClabel/BCdata out (all registered)
//   bad_label sticky flag: a granted request carried label 0
//   bc_count  broadcasts since reset, wraps at 16 bits
module cdb_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 32,
    parameter int unsigned LW   = 5
) (
    input  logic                clk,
    input  logic                nRST,
    input  logic                flush,
    cdb_arbiter_if.slave        bus,
    output logic                bad_label,
    output logic [15:0]         bc_count
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] win_oh;
    logic [PW-1:0]   win;
    logic            found;
    logic [LW-1:0]   win_label;
    logic [DW-1:0]   win_data;
    int unsigned     idx;

    // Last cycle's grantee is masked so a unit still holding req on the edge
    // it samples grant is not granted twice in a row.
    always_comb begin
        elig   = bus.req & ~bus.grant;
        found  = 1'b0;
        win    = '0;
        win_oh = '0;
        idx    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && elig[idx]) begin
                found       = 1'b1;
                win         = PW'(idx);
                win_oh[idx] = 1'b1;
            end
        end
        win_label = bus.req_label[32'(win)*LW +: LW];
        win_data  = bus.req_data[32'(win)*DW +: DW];
        ptr_nxt   = (32'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            bus.grant   <= '0;
            bus.BCEN    <= 1'b0;
            bus.BClabel <= '0;
            bus.BCdata  <= '0;
            bad_label   <= 1'b0;
            bc_count    <= '0;
            ptr         <= '0;
        end else if (flush) begin
            bus.grant <= '0;
            bus.BCEN  <= 1'b0;
            ptr       <= '0;
        end else if (found) begin
            bus.grant   <= win_oh;
            bus.BClabel <= win_label;
            bus.BCdata  <= win_data;
            ptr         <= ptr_nxt;
            // Label 0 is drained (granted) but never broadcast.
            if (win_label != '0) begin
                bus.BCEN <= 1'b1;
                bc_count <= bc_count + 16'd1;
            end else begin
                bus.BCEN  <= 1'b0;
                bad_label <= 1'b1;
            end
        end else begin
            bus.grant <= '0;
            bus.BCEN  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Scoreboard bench for cdb_arbiter: expected bus cycles are queued as the
//   stimulus is applied and compared one per clock, on the falling edge.
module tb_cdb_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned LW   = 5;

    typedef struct {
        logic [NREQ-1:0] grant;
        logic            bcen;
        logic [LW-1:0]   label;
        logic [DW-1:0]   data;
    } exp_t;

    logic        clk;
    logic        nRST;
    logic        flush;
    logic        bad_label;
    logic [15:0] bc_count;

    int total;
    int bad;
    bit auto_drop;
    exp_t sbq[$];

    cdb_arbiter_if #(.NREQ(NREQ), .DW(DW), .LW(LW)) bus ();

    cdb_arbiter #(.NREQ(NREQ), .DW(DW), .LW(LW)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .flush     (flush),
        .bus       (bus),
        .bad_label (bad_label),
        .bc_count  (bc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cycle(input logic [NREQ-1:0] g, input logic en,
                                input logic [LW-1:0] l, input logic [DW-1:0] d);
        exp_t e;
        e.grant = g;
        e.bcen  = en;
        e.label = l;
        e.data  = d;
        sbq.push_back(e);
    endtask

    task automatic set_unit(input int unsigned u, input logic [LW-1:0] l, input logic [DW-1:0] d);
        bus.req_label[u*LW +: LW] = l;
        bus.req_data[u*DW +: DW]  = d;
    endtask

    // One clock; compares the oldest expected entry, then models requesters
    // releasing req once they see their grant.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (sbq.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            check("grant", 64'(bus.grant), 64'(e.grant));
            check("bcen", 64'(bus.BCEN), 64'(e.bcen));
            if (e.bcen) begin
                check("bclabel", 64'(bus.BClabel), 64'(e.label));
                check("bcdata", 64'(bus.BCdata), 64'(e.data));
            end
        end
        if (auto_drop) begin
            bus.req = bus.req & ~bus.grant;
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        auto_drop = 1'b1;
        nRST      = 1'b0;
        flush     = 1'b0;
        bus.req   = 4'b1111;
        for (int unsigned u = 0; u < NREQ; u++) begin
            set_unit(u, LW'(u + 1), 32'h1000_0000 + u);
        end

        // Reset held with all units requesting.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_grant", 64'(bus.grant), 64'd0);
            check("rst_bcen", 64'(bus.BCEN), 64'd0);
            check("rst_count", 64'(bc_count), 64'd0);
        end
        check("rst_bad", 64'(bad_label), 64'd0);
        bus.req = '0;
        nRST    = 1'b1;

        // Single request from unit 0.
        set_unit(0, 5'd1, 32'hDEADBEEF);
        bus.req = 4'b0001;
        expect_cycle(4'b0001, 1'b1, 5'd1, 32'hDEADBEEF);
        cycle();
        expect_cycle(4'b0000, 1'b0, '0, '0);
        cycle();
        check("single_count", 64'(bc_count), 64'd1);

        // Flush with nothing pending brings the pointer back to 0.
        flush = 1'b1;
        expect_cycle(4'b0000, 1'b0, '0, '0);
        cycle();
        flush = 1'b0;

        // Full contention: strict rotation from unit 0.
        for (int unsigned u = 0; u < NREQ; u++) begin
            set_unit(u, LW'(u + 1), 32'hA000_0000 + u);
        end
        bus.req = 4'b1111;
        for (int unsigned u = 0; u < NREQ; u++) begin
            expect_cycle(4'(1 << u), 1'b1, LW'(u + 1), 32'hA000_0000 + u);
        end
        expect_cycle(4'b0000, 1'b0, '0, '0);
        for (int k = 0; k < 5; k++) cycle();
        check("rr_count", 64'(bc_count), 64'd5);

        // Unit 1 keeps requesting: granted only every other cycle.
        auto_drop = 1'b0;
        set_unit(1, 5'd9, 32'h1111_2222);
        bus.req = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            expect_cycle(4'b0010, 1'b1, 5'd9, 32'h1111_2222);
            expect_cycle(4'b0000, 1'b0, '0, '0);
        end
        for (int k = 0; k < 6; k++) cycle();
        bus.req   = '0;
        auto_drop = 1'b1;
        check("rep_count", 64'(bc_count), 64'd8);

        // Label 0 from unit 2 (pointer is at 2): drained, not broadcast.
        set_unit(2, 5'd0, 32'h5555_5555);
        bus.req = 4'b0100;
        expect_cycle(4'b0100, 1'b0, '0, '0);
        expect_cycle(4'b0000, 1'b0, '0, '0);
        cycle();
        check("bad_set", 64'(bad_label), 64'd1);
        cycle();
        check("bad_sticky", 64'(bad_label), 64'd1);
        check("lbl0_count", 64'(bc_count), 64'd8);

        // Flush on the cycle req=0110: nothing granted, then unit 1 then 2.
        set_unit(1, 5'd7, 32'h0000_0077);
        set_unit(2, 5'd3, 32'h0000_0033);
        bus.req = 4'b0110;
        flush   = 1'b1;
        expect_cycle(4'b0000, 1'b0, '0, '0);
        cycle();
        flush = 1'b0;
        check("flush_bad_hold", 64'(bad_label), 64'd1);
        check("flush_count_hold", 64'(bc_count), 64'd8);
        expect_cycle(4'b0010, 1'b1, 5'd7, 32'h0000_0077);
        expect_cycle(4'b0100, 1'b1, 5'd3, 32'h0000_0033);
        expect_cycle(4'b0000, 1'b0, '0, '0);
        for (int k = 0; k < 3; k++) cycle();
        check("flush_count", 64'(bc_count), 64'd10);

        // Async reset while a broadcast is live; the unit re-requests.
        set_unit(0, 5'd4, 32'hCAFE_F00D);
        bus.req   = 4'b0001;
        auto_drop = 1'b0;
        expect_cycle(4'b0001, 1'b1, 5'd4, 32'hCAFE_F00D);
        cycle();
        #2;
        nRST = 1'b0;
        #1;
        check("arst_bcen", 64'(bus.BCEN), 64'd0);
        check("arst_grant", 64'(bus.grant), 64'd0);
        check("arst_count", 64'(bc_count), 64'd0);
        check("arst_bad", 64'(bad_label), 64'd0);
        nRST      = 1'b1;
        auto_drop = 1'b1;
        expect_cycle(4'b0001, 1'b1, 5'd4, 32'hCAFE_F00D);
        expect_cycle(4'b0000, 1'b0, '0, '0);
        cycle();
        cycle();
        check("rereq_count", 64'(bc_count), 64'd1);

        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
